// File: rtl/alien_fire_scheduler_pkg.sv
// Shared definitions for the space-invaders enemy-fire logic: FSM states,
// random-word width, default column geometry and the shot-counter width.
package space_inv_pkg;

  localparam int RAND_W       = 48;
  localparam int DEF_NUM_COLS = 8;
  localparam int DEF_COL_W    = $clog2(DEF_NUM_COLS);
  localparam int SHOT_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PICK,
    ISSUE
  } fire_state_t;

endpackage

// File: rtl/alien_fire_scheduler_if.sv
// Fire-request channel between the enemy-fire scheduler (master) and the
// bullet manager (slave), plus the shot bookkeeping that travels with it.
interface alien_fire_scheduler_if #(
  parameter int COL_W = space_inv_pkg::DEF_COL_W
);
  import space_inv_pkg::*;

  logic              fire_valid;
  logic              fire_ready;
  logic [COL_W-1:0]  fire_col;
  logic              shot_done;
  logic [SHOT_W-1:0] in_flight;

  modport master (
    output fire_valid,
    output fire_col,
    output in_flight,
    input  fire_ready,
    input  shot_done
  );

  modport slave (
    input  fire_valid,
    input  fire_col,
    input  in_flight,
    output fire_ready,
    output shot_done
  );

endinterface

// File: rtl/alien_fire_scheduler_scan.sv
// Rotating alive-column scanner: while active, tests one column per cycle
// starting at 'start' and wrapping modulo NUM_COLS.
module alive_column_scan
  import space_inv_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  localparam int COL_W   = $clog2(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic [COL_W-1:0]    start,
  input  logic [NUM_COLS-1:0] alive,
  output logic                hit,
  output logic [COL_W-1:0]    col,
  output logic                done
);

  logic [COL_W-1:0] step;

  // NUM_COLS is a power of two, so the natural wrap of the adder is the modulo
  assign col  = start + step;
  assign hit  = active && alive[col];
  assign done = active && (step == COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (active && !hit && !done) begin
      step <= step + COL_W'(1);
    end else begin
      step <= '0;
    end
  end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Enemy-fire scheduler: random frame gap, random alive column, one fire request
// per shot, shots-in-flight limit. Optional aimed fire under macro FIRE_AIM_EN.
module alien_fire_scheduler
  import space_inv_pkg::*;
#(
  parameter int NUM_COLS  = DEF_NUM_COLS,
  parameter int MIN_GAP   = 20,
  parameter int GAP_BITS  = 6,
  parameter int MAX_SHOTS = 3,
  localparam int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_tick,
  input  logic [RAND_W-1:0]     random_number,
  input  logic [NUM_COLS-1:0]   alive_cols,
  input  logic [COL_W-1:0]      player_col,
  alien_fire_scheduler_if.master fire
);

  localparam int GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));

  fire_state_t       state;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  fresh_gap;
  logic [COL_W-1:0]  start;
  logic              fire_valid_q;
  logic [COL_W-1:0]  fire_col_q;
  logic [SHOT_W-1:0] in_flight_q;
  logic              pick_go;
  logic              accept;
  logic              retire;
  logic              scan_hit;
  logic              scan_done;
  logic [COL_W-1:0]  scan_col;
  logic              unused_rand;

  assign unused_rand = ^random_number;
  assign fresh_gap   = GAP_W'(MIN_GAP) + GAP_W'(random_number[GAP_BITS-1:0]);
  assign pick_go     = (gap == '0) && (in_flight_q < SHOT_W'(MAX_SHOTS));
  assign accept      = fire_valid_q && fire.fire_ready;
  assign retire      = fire.shot_done && (in_flight_q != '0);

`ifdef FIRE_AIM_EN
  logic pick_first;
  logic aim_hit;
  assign aim_hit = pick_first && random_number[RAND_W-1] && alive_cols[player_col];
`else
  logic unused_player;
  assign unused_player = ^player_col;
`endif

  alive_column_scan #(.NUM_COLS(NUM_COLS)) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (state == PICK),
    .start  (start),
    .alive  (alive_cols),
    .hit    (scan_hit),
    .col    (scan_col),
    .done   (scan_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap          <= '0;
      start        <= '0;
      fire_valid_q <= 1'b0;
      fire_col_q   <= '0;
`ifdef FIRE_AIM_EN
      pick_first   <= 1'b0;
`endif
    end else begin
`ifdef FIRE_AIM_EN
      pick_first <= enable && (state == WAIT) && pick_go;
`endif
      if (!enable) begin
        state        <= IDLE;
        fire_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT;
            gap   <= fresh_gap;
          end
          // a zero gap parks here while the screen already holds MAX_SHOTS bullets
          WAIT: begin
            if (gap == '0) begin
              if (pick_go) begin
                state <= PICK;
                start <= random_number[24 +: COL_W];
              end
            end else if (frame_tick) begin
              gap <= gap - GAP_W'(1);
            end
          end
          PICK: begin
`ifdef FIRE_AIM_EN
            if (aim_hit) begin
              fire_col_q   <= player_col;
              fire_valid_q <= 1'b1;
              state        <= ISSUE;
            end else
`endif
            if (scan_hit) begin
              fire_col_q   <= scan_col;
              fire_valid_q <= 1'b1;
              state        <= ISSUE;
            end else if (scan_done) begin
              state <= WAIT;
              gap   <= fresh_gap;
            end
          end
          ISSUE: begin
            if (fire.fire_ready) begin
              fire_valid_q <= 1'b0;
              state        <= WAIT;
              gap          <= fresh_gap;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // shot_done keeps counting even while the game is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= '0;
    end else if (accept && !retire && (in_flight_q < SHOT_W'(MAX_SHOTS))) begin
      in_flight_q <= in_flight_q + SHOT_W'(1);
    end else if (retire && !accept) begin
      in_flight_q <= in_flight_q - SHOT_W'(1);
    end
  end

  assign fire.fire_valid = fire_valid_q;
  assign fire.fire_col   = fire_col_q;
  assign fire.in_flight  = in_flight_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Bench for alien_fire_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_alien_fire_scheduler;
  import space_inv_pkg::*;

  localparam int NUM_COLS  = 8;
  localparam int MIN_GAP   = 20;
  localparam int GAP_BITS  = 6;
  localparam int MAX_SHOTS = 3;
  localparam int COL_W     = 3;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_PICK  = 2;
  localparam int M_ISSUE = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              frame_tick = 1'b0;
  logic [RAND_W-1:0] random_number = '0;
  logic [7:0]        alive_cols = 8'hFF;
  logic [2:0]        player_col = 3'd0;

  alien_fire_scheduler_if #(.COL_W(COL_W)) fi ();

  alien_fire_scheduler #(
    .NUM_COLS  (NUM_COLS),
    .MIN_GAP   (MIN_GAP),
    .GAP_BITS  (GAP_BITS),
    .MAX_SHOTS (MAX_SHOTS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .frame_tick    (frame_tick),
    .random_number (random_number),
    .alive_cols    (alive_cols),
    .player_col    (player_col),
    .fire          (fi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  // Behavioural view: a phase, a frame countdown, a scan position and the shot tally
  int m_mode, m_gap, m_start, m_step, m_valid, m_col, m_flight;
  int old_flight, cand;
  bit took;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit tick, input logic [RAND_W-1:0] rnd,
                               input logic [7:0] alive, input bit ready, input bit done);
    enable        = en;
    frame_tick    = tick;
    random_number = rnd;
    alive_cols    = alive;
    fi.fire_ready = ready;
    fi.shot_done  = done;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic [RAND_W-1:0] rnd, input logic [7:0] alive);
    repeat (n) applyStimulus(1'b1, 1'b1, rnd, alive, 1'b0, 1'b0);
  endtask

  function automatic logic [RAND_W-1:0] r(input int s);
    return RAND_W'(s) << 24;
  endfunction

  function automatic int freshGap();
    return MIN_GAP + int'(random_number[GAP_BITS-1:0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_gap = 0; m_start = 0; m_step = 0;
      m_valid = 0; m_col = 0; m_flight = 0;
    end else begin
      old_flight = m_flight;
      took = (m_valid == 1) && fi.fire_ready;
      if (took && !(fi.shot_done && old_flight > 0))
        m_flight = (old_flight < MAX_SHOTS) ? old_flight + 1 : old_flight;
      else if (!took && fi.shot_done && old_flight > 0)
        m_flight = old_flight - 1;

      if (!enable) begin
        m_mode = M_IDLE;
        m_valid = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_WAIT;
        m_gap = freshGap();
      end else if (m_mode == M_WAIT) begin
        if (m_gap == 0) begin
          if (old_flight < MAX_SHOTS) begin
            m_mode = M_PICK;
            m_start = int'(random_number[26:24]);
            m_step = 0;
          end
        end else if (frame_tick) begin
          m_gap = m_gap - 1;
        end
      end else if (m_mode == M_PICK) begin
        cand = (m_start + m_step) % NUM_COLS;
`ifdef FIRE_AIM_EN
        if (m_step == 0 && random_number[47] && alive_cols[player_col])
          cand = int'(player_col);
`endif
        if (alive_cols[cand] && (m_step == 0 || cand == (m_start + m_step) % NUM_COLS)) begin
          m_mode = M_ISSUE; m_valid = 1; m_col = cand;
        end else if (m_step == NUM_COLS - 1) begin
          m_mode = M_WAIT; m_gap = freshGap();
        end else begin
          m_step = m_step + 1;
        end
      end else begin
        if (fi.fire_ready) begin
          m_mode = M_WAIT; m_valid = 0; m_gap = freshGap();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      checkOutput("model_fire_valid", int'(fi.fire_valid), m_valid);
      checkOutput("model_fire_col", int'(fi.fire_col), m_col);
      checkOutput("model_in_flight", int'(fi.in_flight), m_flight);
    end
  end

  initial begin
    fi.fire_ready = 1'b0;
    fi.shot_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_fire_valid", int'(fi.fire_valid), 0);
    checkOutput("reset_fire_col", int'(fi.fire_col), 0);
    checkOutput("reset_in_flight", int'(fi.in_flight), 0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    applyStimulus(1'b0, 1'b0, '0, 8'hFF, 1'b0, 1'b1);
    checkOutput("shot_done_at_zero", int'(fi.in_flight), 0);

    // 25-frame gap, start 3, all alive, ready tied high
    applyStimulus(1'b1, 1'b0, RAND_W'(5), 8'hFF, 1'b1, 1'b0);
    repeat (24) applyStimulus(1'b1, 1'b1, r(3), 8'hFF, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, r(3), 8'hFF, 1'b1, 1'b0);
    checkOutput("gap_one_left", int'(fi.fire_valid), 0);
    applyStimulus(1'b1, 1'b1, r(3), 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, r(3), 8'hFF, 1'b1, 1'b0);
    checkOutput("pick_entry_no_valid", int'(fi.fire_valid), 0);
    applyStimulus(1'b1, 1'b0, r(3), 8'hFF, 1'b1, 1'b0);
    checkOutput("first_shot_valid", int'(fi.fire_valid), 1);
    checkOutput("first_shot_col", int'(fi.fire_col), 3);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b1, 1'b0);
    checkOutput("first_accept_valid", int'(fi.fire_valid), 0);
    checkOutput("first_accept_flight", int'(fi.in_flight), 1);

    // sparse columns: start 2 reaches column 6 at scan step 4
    ticks(20, r(2), 8'h41);
    applyStimulus(1'b1, 1'b0, r(2), 8'h41, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, r(0), 8'h41, 1'b0, 1'b0);
      checkOutput("scan_latency", int'(fi.fire_valid), (i == 5) ? 1 : 0);
    end
    checkOutput("scan_col", int'(fi.fire_col), 6);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, r(0), (i < 5) ? 8'h41 : 8'h01, 1'b0, 1'b0);
      checkOutput("stall_valid", int'(fi.fire_valid), 1);
      checkOutput("stall_col", int'(fi.fire_col), 6);
    end
    applyStimulus(1'b1, 1'b0, r(0), 8'h01, 1'b1, 1'b0);
    checkOutput("second_accept_flight", int'(fi.in_flight), 2);

    // no alive column: eight empty scan steps, back to WAIT with a fresh gap
    ticks(20, r(0), 8'h00);
    applyStimulus(1'b1, 1'b0, r(0), 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, (i == 8) ? r(0) : RAND_W'(63), 8'h00, 1'b0, 1'b0);
      checkOutput("empty_scan_valid", int'(fi.fire_valid), 0);
    end
    ticks(20, r(4), 8'hFF);
    applyStimulus(1'b1, 1'b0, r(4), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    checkOutput("after_empty_valid", int'(fi.fire_valid), 1);
    checkOutput("after_empty_col", int'(fi.fire_col), 4);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b1, 1'b0);
    checkOutput("third_accept_flight", int'(fi.in_flight), 3);

    // full screen holds the scheduler until one bullet retires
    ticks(20, r(1), 8'hFF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, r(1), 8'hFF, 1'b0, 1'b0);
      checkOutput("held_at_max_valid", int'(fi.fire_valid), 0);
      checkOutput("held_at_max_flight", int'(fi.in_flight), 3);
    end
    applyStimulus(1'b1, 1'b0, r(1), 8'hFF, 1'b0, 1'b1);
    checkOutput("retire_flight", int'(fi.in_flight), 2);
    applyStimulus(1'b1, 1'b0, r(1), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    checkOutput("resume_valid", int'(fi.fire_valid), 1);
    checkOutput("resume_col", int'(fi.fire_col), 1);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b1, 1'b1);
    checkOutput("accept_with_retire_flight", int'(fi.in_flight), 2);
    checkOutput("accept_with_retire_valid", int'(fi.fire_valid), 0);

    // enable withdrawn while a request is pending
    ticks(20, r(5), 8'hFF);
    applyStimulus(1'b1, 1'b0, r(5), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    checkOutput("pre_disable_valid", int'(fi.fire_valid), 1);
    applyStimulus(1'b0, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    checkOutput("disable_drops_valid", int'(fi.fire_valid), 0);

    // asynchronous reset in the middle of a long scan
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    ticks(20, r(0), 8'h80);
    repeat (3) applyStimulus(1'b1, 1'b0, r(0), 8'h80, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", int'(fi.fire_valid), 0);
    checkOutput("async_reset_col", int'(fi.fire_col), 0);
    checkOutput("async_reset_flight", int'(fi.in_flight), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // aimed shot at the player column, then with that column dead
    player_col = 3'd5;
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b0, 1'b0);
    ticks(20, r(2), 8'hFF);
    applyStimulus(1'b1, 1'b0, r(2), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 48'h8000_0000_0000, 8'hFF, 1'b0, 1'b0);
    checkOutput("aim_valid", int'(fi.fire_valid), 1);
`ifdef FIRE_AIM_EN
    checkOutput("aim_col", int'(fi.fire_col), 5);
`else
    checkOutput("aim_col", int'(fi.fire_col), 2);
`endif
    applyStimulus(1'b1, 1'b0, r(0), 8'hFF, 1'b1, 1'b0);
    ticks(20, r(2), 8'hDF);
    applyStimulus(1'b1, 1'b0, r(2), 8'hDF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 48'h8000_0000_0000, 8'hDF, 1'b0, 1'b0);
    checkOutput("aim_dead_valid", int'(fi.fire_valid), 1);
    checkOutput("aim_dead_col", int'(fi.fire_col), 2);
    applyStimulus(1'b1, 1'b0, r(0), 8'hDF, 1'b1, 1'b0);
    checkOutput("aim_dead_flight", int'(fi.in_flight), 2);

    // randomized traffic
    begin
      logic [7:0] alive_r;
      alive_r = 8'hFF;
      for (int c = 0; c < 6000; c++) begin
        if (c % 64 == 0)
          alive_r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
        player_col = 3'($urandom_range(0, 7));
        applyStimulus($urandom_range(0, 299) != 0,
                      $urandom_range(0, 2) == 0,
                      {16'($urandom()), 32'($urandom())},
                      alive_r,
                      $urandom_range(0, 1) == 1,
                      (m_flight > 0) && ($urandom_range(0, 149) == 0));
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

Decides when and from which alien column the next enemy shot is fired, consuming the free-running 48-bit pseudo-random word from the random generator. Sits between the random generator and the bullet manager. Waits a random number of frames, picks a random alive column, then offers one fire request over a valid/ready handshake. Tracks shots in flight so the screen never exceeds `MAX_SHOTS` enemy bullets.

## Interface
- `NUM_COLS`, 8, alien columns; power of two, 2..16; `COL_W = $clog2(NUM_COLS)`.
- `MIN_GAP`, 20, minimum frames between shots.
- `GAP_BITS`, 6, random frames added to `MIN_GAP`; range 0..2^GAP_BITS-1.
- `MAX_SHOTS`, 3, maximum enemy bullets in flight; 1..7.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: game running; low forces IDLE.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `random_number` in 48: random word, new value every cycle.
- `alive_cols` in NUM_COLS: bit c = column c has at least one live alien.
- `player_col` in COL_W: column under the player; used only with `FIRE_AIM_EN`.
- `shot_done` in 1: pulse when an enemy bullet leaves play.
- `fire_ready` in 1: bullet manager accepts the request.
- `fire_valid` out 1: fire request pending.
- `fire_col` out COL_W: column to fire from; stable while `fire_valid` is high.
- `in_flight` out 3: enemy bullets currently in play.

## Operation
- States: IDLE, WAIT, PICK, ISSUE.
- **IDLE**
  - When `enable` is high: go to WAIT and load `gap = MIN_GAP + random_number[GAP_BITS-1:0]`.
- **WAIT**
  - Each `frame_tick` decrements `gap`; `gap` saturates at 0.
  - When `gap == 0` and `in_flight < MAX_SHOTS`: go to PICK and latch `start = random_number[24 +: COL_W]`. Sampled every cycle, not only on ticks.
  - While `in_flight == MAX_SHOTS`: hold at `gap == 0`.
- **PICK**
  - Scan step i = 0..NUM_COLS-1, one column per cycle; column `(start + i) mod NUM_COLS`.
  - First alive column: latch it into `fire_col`, go to ISSUE.
  - No alive column after NUM_COLS steps: go to WAIT with a fresh gap, no shot.
- **ISSUE**
  - `fire_valid` is high.
  - On `fire_valid && fire_ready`: `in_flight` +1, go to WAIT with a fresh gap.
  - `fire_col` is held even if that column dies meanwhile; the bullet manager resolves it.
- **in_flight counter**
  - Accept and `shot_done` in the same cycle: counter unchanged.
  - `shot_done` at 0: ignored.
  - Never exceeds `MAX_SHOTS`.
- **enable low**
  - From any state, next cycle: IDLE, `fire_valid` = 0. This is the only allowed withdrawal of `fire_valid`.
  - `in_flight` keeps counting `shot_done`.
- **Reset values**
  - state IDLE; `fire_valid` 0; `fire_col` 0; `in_flight` 0; `gap` 0; `start` 0.

## Timing
- All outputs registered.
- `gap` load occurs on the cycle the state enters WAIT.
- Tick latency: the `frame_tick` that makes `gap` reach 0 gives PICK on the next cycle, if `in_flight` permits.
- Scan latency: a hit at scan step k gives `fire_valid` high k+1 cycles after entering PICK. Worst case is NUM_COLS cycles.
- A `frame_tick` arriving outside WAIT is ignored.
- With `MIN_GAP = 0` and a random offset of 0: PICK follows the WAIT entry by one cycle.
- Handshake: transfer occurs on the cycle where `fire_valid && fire_ready` are both high. `fire_valid` drops the next cycle. No back-to-back fires.

## Configuration
- Macro: `FIRE_AIM_EN`.
- Defined: on PICK entry, if `random_number[47]` is 1 and `alive_cols[player_col]` is set:
  - `fire_col = player_col`; ISSUE next cycle, so the scan is skipped.
  - Otherwise: normal scan.
- Undefined: `player_col` is ignored; pure random scan.

## Structure
- Shared package `space_inv_pkg` holds:
  - State enum `fire_state_t`.
  - `RAND_W = 48`.
  - `NUM_COLS` default and `COL_W`.
  - Shot-count width.
- Sub-module `alive_column_scan`: the sequential rotating scanner (start, alive mask → hit, col, done).
- The top level holds the FSM, gap counter and `in_flight` counter.

## Test plan
- Defaults, rnd[5:0] = 5, all alive, `start` = 3, `fire_ready` tied 1 → `fire_valid` 1 cycle after PICK entry; `fire_col` = 3; PICK entered the cycle after the 25th `frame_tick`.
- `alive_cols` = 8'b0100_0001, `start` = 2 → `fire_col` = 6, `fire_valid` 5 cycles after PICK entry; `alive_cols` = 0 → no `fire_valid`, back to WAIT after 8 cycles.
- `fire_ready` held 0 for 10 cycles → `fire_valid` and `fire_col` stable for 10 cycles; accept increments `in_flight` to 1.
- Three accepts, no `shot_done` → `in_flight` = 3, held in WAIT at `gap` 0. One `shot_done` → PICK the next cycle. Accept coinciding with `shot_done` → `in_flight` unchanged.
- `enable` dropped during ISSUE → `fire_valid` 0 and IDLE next cycle. `rst_n` low mid-PICK → all outputs at reset values immediately.
- `FIRE_AIM_EN` defined, `random_number[47]` = 1, `player_col` = 5 alive → `fire_col` = 5 the cycle after PICK entry. `player_col` dead → normal scan result.
